// File: rtl/div_ctrl.sv
// Multi-cycle restoring divider for DIV/DIVU: one shift/subtract step per cycle,
// returns {remainder, quotient} with MIPS sign rules; divide-by-zero yields 0.
module div_ctrl #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o,
    output logic                busy_o
);

    typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2*DATA_W:0]     w_q, w_d;
    logic [DATA_W-1:0]     dvs_q, dvs_d;
    logic                  sdiv_q, sdiv_d;
    logic                  neg1_q, neg1_d;
    logic                  neg2_q, neg2_d;
    logic [2*DATA_W-1:0]   result_q, result_d;

    logic [DATA_W:0]       t;
    logic [DATA_W-1:0]     a_abs, b_abs, q_fin, r_fin;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            w_q      <= '0;
            dvs_q    <= '0;
            sdiv_q   <= 1'b0;
            neg1_q   <= 1'b0;
            neg2_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            w_q      <= w_d;
            dvs_q    <= dvs_d;
            sdiv_q   <= sdiv_d;
            neg1_q   <= neg1_d;
            neg2_q   <= neg2_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        w_d      = w_q;
        dvs_d    = dvs_q;
        sdiv_d   = sdiv_q;
        neg1_d   = neg1_q;
        neg2_d   = neg2_q;
        result_d = result_q;

        // Magnitudes: INT_MIN negates to itself, which is the correct unsigned magnitude.
        a_abs = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
        b_abs = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

        t = {1'b0, w_q[2*DATA_W-1:DATA_W]} - {1'b0, dvs_q};

        q_fin = w_q[DATA_W-1:0];
        r_fin = w_q[2*DATA_W:DATA_W+1];
        if (sdiv_q && (neg1_q ^ neg2_q)) q_fin = -w_q[DATA_W-1:0];
        if (sdiv_q && neg1_q)            r_fin = -w_q[2*DATA_W:DATA_W+1];

        case (state_q)
            S_IDLE: begin
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = S_BYZERO;
                    end else begin
                        state_d = S_ON;
                        sdiv_d  = signed_div_i;
                        neg1_d  = opdata1_i[DATA_W-1];
                        neg2_d  = opdata2_i[DATA_W-1];
                        dvs_d   = b_abs;
                        w_d     = {{DATA_W{1'b0}}, a_abs, 1'b0};
                        cnt_d   = '0;
                    end
                end
            end
            S_BYZERO: begin
                state_d  = S_END;
                result_d = '0;
            end
            S_ON: begin
                if (annul_i) begin
                    state_d  = S_IDLE;
                    result_d = '0;
                    cnt_d    = '0;
                end else if (cnt_q == CNT_W'(DATA_W)) begin
                    state_d  = S_END;
                    result_d = {r_fin, q_fin};
                end else begin
                    if (t[DATA_W]) w_d = {w_q[2*DATA_W-1:0], 1'b0};
                    else           w_d = {t[DATA_W-1:0], w_q[DATA_W-1:0], 1'b1};
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_END: begin
                if (!start_i || annul_i) begin
                    state_d  = S_IDLE;
                    result_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign result_o = result_q;
    assign ready_o  = (state_q == S_END);
    assign busy_o   = (state_q == S_BYZERO) || (state_q == S_ON);

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: driver queues expected results and latency,
// monitor checks each rising ready_o against the queue head.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div;
    logic [31:0] op1, op2;
    logic        start, annul;
    logic [63:0] result;
    logic        ready, busy;

    typedef struct {
        logic [63:0] res;
        int          lat;
        int          acc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_mis = 0;
    logic rdy_prev = 1'b0;

    div_ctrl #(.DATA_W(32), .CNT_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .signed_div_i(signed_div),
        .opdata1_i   (op1),
        .opdata2_i   (op2),
        .start_i     (start),
        .annul_i     (annul),
        .result_o    (result),
        .ready_o     (ready),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every rising ready_o must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst && ready && !rdy_prev) begin
            if (sb.size() == 0) begin
                n_cmp++; n_mis++;
                $display("FAIL unexpected_ready: got result %h with nothing queued", result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_result"}, result, e.res);
                chk({e.name, "_latency"}, 64'(cyc - e.acc), 64'(e.lat));
            end
        end
        rdy_prev = ready;
    end

    task automatic run_div(input string nm, input bit sg, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp, input int lat,
                           input int hold);
        int n;
        @(negedge clk);
        signed_div = sg; op1 = a; op2 = b; annul = 1'b0; start = 1'b1;
        sb.push_back('{exp, lat, cyc + 1, nm});
        @(negedge clk);
        chk({nm, "_busy"}, 64'(busy), 64'd1);
        op1 = $urandom; op2 = $urandom; signed_div = ~sg;
        n = 0;
        while (!ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            n_cmp++; n_mis++;
            $display("FAIL %s_timeout: ready never rose within %0d cycles", nm, n);
            void'(sb.pop_front());
        end else begin
            repeat (hold) @(negedge clk);
            chk({nm, "_end_hold_ready"}, 64'(ready), 64'd1);
            chk({nm, "_end_hold_result"}, result, exp);
        end
        start = 1'b0;
        @(posedge clk); #1;
        chk({nm, "_drop_ready"}, 64'(ready), 64'd0);
        chk({nm, "_drop_result"}, result, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; start = 1'b0; annul = 1'b0; signed_div = 1'b0; op1 = '0; op2 = '0;
        #12;
        chk("reset_result", result, 64'd0);
        chk("reset_ready", 64'(ready), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        @(negedge clk); rst = 1'b1;

        run_div("u100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 3);
        run_div("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33, 0);
        run_div("s_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33, 0);
        run_div("s_m100_m7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 64'hFFFFFFFE_0000000E, 33, 0);
        run_div("u3_5", 1'b0, 32'd3, 32'd5, 64'h00000003_00000000, 33, 0);
        // Zero divisor: BYZERO occupies exactly one cycle before END.
        run_div("byzero", 1'b0, 32'h12345678, 32'd0, 64'd0, 1, 1);

        // Annul mid-divide, then restart straight away.
        @(negedge clk);
        signed_div = 1'b0; op1 = 32'hFFFFFFFF; op2 = 32'd1; start = 1'b1;
        repeat (9) @(negedge clk);
        annul = 1'b1;
        @(posedge clk); #1;
        chk("annul_busy", 64'(busy), 64'd0);
        chk("annul_ready", 64'(ready), 64'd0);
        chk("annul_result", result, 64'd0);
        run_div("restart_ffff_10", 1'b0, 32'hFFFFFFFF, 32'h10, 64'h0000000F_0FFFFFFF, 33, 0);

        run_div("s_intmin_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33, 0);
        run_div("u_8000_ffff", 1'b0, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, 33, 0);

        // start and annul together in IDLE must not launch a divide.
        @(negedge clk);
        op1 = 32'd9; op2 = 32'd3; start = 1'b1; annul = 1'b1;
        repeat (2) @(negedge clk);
        chk("start_annul_idle_busy", 64'(busy), 64'd0);
        chk("start_annul_idle_ready", 64'(ready), 64'd0);
        start = 1'b0; annul = 1'b0;

        // Asynchronous reset in the middle of a divide.
        @(negedge clk);
        signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
        repeat (20) @(negedge clk);
        chk("pre_reset_busy", 64'(busy), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_result", result, 64'd0);
        chk("async_rst_ready", 64'(ready), 64'd0);
        chk("async_rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        start = 1'b0; rst = 1'b1;
        run_div("after_rst_u100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 0);

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            n_cmp++; n_mis++;
            $display("FAIL scoreboard_drain: %0d results outstanding, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
